// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU control codes and the internal Moore control bundle.
package mips_mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // Moore outputs of one state, before reset gating and the branch term.
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU control decode: maps the FSM's aluop class plus the R-type funct field
// onto the 3-bit ALU operation code.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath and
// unified memory, with combinational ALU decode and branch-qualified PC enable.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int TRAP_UNKNOWN = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       halted
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = (TRAP_UNKNOWN != 0) ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_HALT:    state_d = S_HALT;
      // Write-back/branch/jump states and the unused codes 13-15 all restart.
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
      end
      S_DECODE: ctrl.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JEX: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

  mips_mc_aludec u_aludec (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Write enables are gated by reset directly so a memory write in flight
  // is cut combinationally, without waiting for a clock edge.
  assign pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
  assign irwrite  = ~reset & ctrl.irwrite;
  assign regwrite = ~reset & ctrl.regwrite;
  assign memwrite = ~reset & ctrl.memwrite;

  assign iord     = ctrl.iord;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign halted   = ctrl.halted;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller: two instances (no trap / trap on
// unknown opcode) checked every cycle against an instruction-level model.
module tb_mips_mc_controller;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       halted;
  } outs_t;

  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001000, T_J = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;

  logic       pcen0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0, halted0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] alucontrol0;
  logic [3:0] state0;
  logic       pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1, halted1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] alucontrol1;
  logic [3:0] state1;
  outs_t      o0, o1;

  int  total = 0;
  int  bad = 0;
  int  exp_s0 = 0;
  int  exp_s1 = 0;
  bit  active = 1'b0;
  bit  halt1 = 1'b0;
  bit  pending_release = 1'b0;

  mips_mc_controller #(.TRAP_UNKNOWN(0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen0), .iord(iord0), .memwrite(memwrite0), .irwrite(irwrite0),
    .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0), .alusrca(alusrca0),
    .alusrcb(alusrcb0), .pcsrc(pcsrc0), .alucontrol(alucontrol0), .state(state0),
    .halted(halted0)
  );

  mips_mc_controller #(.TRAP_UNKNOWN(1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen1), .iord(iord1), .memwrite(memwrite1), .irwrite(irwrite1),
    .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1),
    .alusrcb(alusrcb1), .pcsrc(pcsrc1), .alucontrol(alucontrol1), .state(state1),
    .halted(halted1)
  );

  assign o0 = {pcen0, iord0, memwrite0, irwrite0, regdst0, memtoreg0, regwrite0,
               alusrca0, alusrcb0, pcsrc0, alucontrol0, state0, halted0};
  assign o1 = {pcen1, iord1, memwrite1, irwrite1, regdst1, memtoreg1, regwrite1,
               alusrca1, alusrcb1, pcsrc1, alucontrol1, state1, halted1};

  always #5 clk = ~clk;

  // Expected outputs for a given state number, straight from the output table.
  function automatic outs_t model(input int s, input logic [5:0] f, input logic z, input logic r);
    outs_t o;
    logic  pcw, br;
    int    aop;
    o = '0; pcw = 1'b0; br = 1'b0; aop = 0;
    o.state = s[3:0];
    case (s)
      0:  begin o.irwrite = 1'b1; pcw = 1'b1; o.alusrcb = 2'b01; end
      1:  o.alusrcb = 2'b11;
      2, 9: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      6:  begin o.alusrca = 1'b1; aop = 2; end
      7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      8:  begin o.alusrca = 1'b1; aop = 1; o.pcsrc = 2'b01; br = 1'b1; end
      10: o.regwrite = 1'b1;
      11: begin o.pcsrc = 2'b10; pcw = 1'b1; end
      12: o.halted = 1'b1;
      default: o.halted = 1'b0;
    endcase
    o.pcen = pcw | (br & z);
    if (aop == 1) o.alucontrol = 3'b110;
    else if (aop == 2) begin
      if      (f == 6'b100000) o.alucontrol = 3'b010;
      else if (f == 6'b100010) o.alucontrol = 3'b110;
      else if (f == 6'b100100) o.alucontrol = 3'b000;
      else if (f == 6'b100101) o.alucontrol = 3'b001;
      else if (f == 6'b101010) o.alucontrol = 3'b111;
      else                     o.alucontrol = 3'b010;
    end else o.alucontrol = 3'b010;
    if (r) begin
      o.pcen = 1'b0; o.irwrite = 1'b0; o.regwrite = 1'b0; o.memwrite = 1'b0;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    outs_t e;
    if (active) begin
      e = model(exp_s0, funct, zero, reset);
      total++;
      if (o0 !== e) begin
        bad++;
        $display("FAIL cycle_dut0 t=%0t got=%h want=%h", $time, o0, e);
      end
      e = model(exp_s1, funct, zero, reset);
      total++;
      if (o1 !== e) begin
        bad++;
        $display("FAIL cycle_dut1 t=%0t got=%h want=%h", $time, o1, e);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, want);
    end
  endtask

  // Advance one clock and declare which state each instance must now be in.
  task automatic step(input int s, input int z);
    @(posedge clk);
    #1;
    if (pending_release) begin
      reset = 1'b0;
      pending_release = 1'b0;
    end
    exp_s0 = s;
    exp_s1 = halt1 ? 12 : s;
    active = 1'b1;
    zero = (z < 0) ? 1'($urandom_range(0, 1)) : 1'(z);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1; halt1 = 1'b0; exp_s0 = 0; exp_s1 = 0; active = 1'b1;
      #1;
      chk("rst_state", int'(state0), 0);
      chk("rst_enables", int'({pcen0, irwrite0, regwrite0, memwrite0}), 0);
      chk("rst_state1", int'(state1), 0);
    end
    pending_release = 1'b1;
  endtask

  // State walk derived from each instruction's latency and the states it visits.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f);
    int seq[5];
    int n;
    bit known;
    known = 1'b1;
    seq = '{0, 1, 0, 0, 0};
    n = 2;
    case (o)
      T_LW:    begin seq = '{0, 1, 2, 3, 4}; n = 5; end
      T_SW:    begin seq = '{0, 1, 2, 5, 0}; n = 4; end
      T_R:     begin seq = '{0, 1, 6, 7, 0}; n = 4; end
      T_ADDI:  begin seq = '{0, 1, 9, 10, 0}; n = 4; end
      T_BEQ:   begin seq = '{0, 1, 8, 0, 0}; n = 3; end
      T_J:     begin seq = '{0, 1, 11, 0, 0}; n = 3; end
      default: known = 1'b0;
    endcase
    for (int k = 0; k < n; k++) begin
      step(seq[k], -1);
      if (k == 0) begin op = o; funct = f; end
    end
    if (!known) halt1 = 1'b1;
  endtask

  initial begin
    logic [5:0] unk[4];
    logic [5:0] r_op;
    unk = '{6'b111111, 6'b000011, 6'b001101, 6'b100000};

    do_reset(3);

    // lw with hand-computed expectations
    step(0, -1); op = T_LW; funct = 6'($urandom);
    chk("first_pcen", int'(pcen0), 1);
    chk("first_irwrite", int'(irwrite0), 1);
    step(1, -1);
    step(2, -1); chk("lw_memadr_alu", int'(alucontrol0), 2);
    step(3, -1); chk("lw_memrd_iord", int'(iord0), 1);
    step(4, -1); chk("lw_memwb_wr", int'({memtoreg0, regwrite0}), 3);

    // sw
    step(0, -1); op = T_SW;
    step(1, -1);
    step(2, -1);
    step(5, -1); chk("sw_memwr", int'({memwrite0, iord0, regwrite0}), 6);

    // R-type slt, sub, unknown funct
    step(0, -1); op = T_R; funct = 6'b101010;
    step(1, -1);
    step(6, -1); chk("rtype_slt", int'(alucontrol0), 7);
    step(7, -1); chk("rtype_wb", int'({regdst0, regwrite0}), 3);
    run_instr(T_R, 6'b100010);
    chk("rtype_sub_state", int'(state0), 7);
    step(0, -1); op = T_R; funct = 6'b110000;
    step(1, -1);
    step(6, -1); chk("rtype_dflt", int'(alucontrol0), 2);
    step(7, -1);

    // beq taken / not taken, then j
    step(0, -1); op = T_BEQ;
    step(1, -1);
    step(8, 1); chk("beq_taken", int'({pcen0, pcsrc0}), 5);
    step(0, -1); op = T_BEQ;
    step(1, -1);
    step(8, 0); chk("beq_nottaken", int'(pcen0), 0);
    step(0, -1); op = T_J;
    step(1, -1);
    step(11, -1); chk("jex", int'({pcen0, pcsrc0}), 6);

    // unknown opcode: dut0 skips, dut1 halts and stays halted
    run_instr(6'b111111, 6'd0);
    for (int i = 0; i < 4; i++) begin
      run_instr(T_J, 6'd0);
      chk("halt_hold", int'({halted1, state1}), 16 + 12);
      chk("halt_enables", int'({pcen1, irwrite1, regwrite1, memwrite1}), 0);
    end
    do_reset(1);

    // reset pulsed inside MEMWR cuts memwrite with no clock edge
    step(0, -1); op = T_SW;
    step(1, -1);
    step(2, -1);
    step(5, -1); chk("memwr_before", int'(memwrite0), 1);
    #1;
    reset = 1'b1; exp_s0 = 0; exp_s1 = 0; halt1 = 1'b0;
    #1;
    chk("memwr_cut", int'(memwrite0), 0);
    chk("memwr_cut_state", int'(state0), 0);
    do_reset(2);

    // randomized instruction stream with occasional resets
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 11) == 0) do_reset(int'($urandom_range(1, 3)));
      case ($urandom_range(0, 6))
        0: r_op = T_LW;
        1: r_op = T_SW;
        2: r_op = T_R;
        3: r_op = T_BEQ;
        4: r_op = T_ADDI;
        5: r_op = T_J;
        default: r_op = unk[$urandom_range(0, 3)];
      endcase
      run_instr(r_op, 6'($urandom));
    end

    @(posedge clk);
    active = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
Multicycle control unit that sequences the shared MIPS datapath, where one unified memory serves both instruction fetch and data access. It is a Moore FSM that decodes opcode and funct and drives all datapath selects and write enables. It sits inside the mips top between the instruction register and the datapath, and it replaces the single-cycle maindec/aludec pair.

Parameters:
TRAP_UNKNOWN, 0, when 1 an unsupported opcode enters HALT; when 0 it is treated as a NOP.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
pcen  output  1  PC register enable (pcwrite | (branch & zero))
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  destination register: 0 = rt, 1 = rd
memtoreg  output  1  write-back source: 1 = memory data register
regwrite  output  1  register file write
alusrca  output  1  ALU A input: 0 = PC, 1 = register A
alusrcb  output  2  ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  output  3  ALU operation
state  output  4  current state, for debug display
halted  output  1  high while in HALT

Behaviour:
- Reset (asynchronous): state goes to FETCH. While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0. All other outputs take their FETCH values. halted = 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, HALT 12. Encodings 13-15 go to FETCH on the next clock.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw/sw -> MEMADR; R-type (000000) -> RTYPEEX; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX; any other opcode -> HALT if TRAP_UNKNOWN, else FETCH.
  - MEMADR: lw (100011) -> MEMRD, sw (101011) -> MEMWR.
  - MEMRD -> MEMWB. RTYPEEX -> RTYPEWB. ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
  - HALT stays in HALT until reset.
- Moore outputs. Every signal not listed for a state is 0, and aluop defaults to 00.
  - FETCH: irwrite = 1, pcwrite = 1, alusrcb = 01.
  - DECODE: alusrcb = 11.
  - MEMADR and ADDIEX: alusrca = 1, alusrcb = 10.
  - MEMRD: iord = 1.
  - MEMWB: memtoreg = 1, regwrite = 1.
  - MEMWR: iord = 1, memwrite = 1.
  - RTYPEEX: alusrca = 1, aluop = 10.
  - RTYPEWB: regdst = 1, regwrite = 1.
  - BEQEX: alusrca = 1, aluop = 01, pcsrc = 01, branch = 1.
  - ADDIWB: regwrite = 1.
  - JEX: pcsrc = 10, pcwrite = 1.
  - HALT: all outputs 0, halted = 1.
- pcen = pcwrite | (branch & zero). This path is combinational on zero and resolves in the same cycle as BEQEX.
- ALU decode (combinational):
  - aluop 00 -> 010 (add); aluop 01 -> 110 (sub).
  - aluop 10 uses funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010.
  - aluop 11 -> 010.
- Instruction latency in clocks, FETCH inclusive: lw 5; sw, R-type and addi 4; beq and j 3; unknown opcode 2 when TRAP_UNKNOWN = 0.
- Reset asserted mid-instruction aborts it immediately. A memwrite asserted in MEMWR is cut the moment reset goes high.

Decomposition:
- Shared package: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, ALU control codes, aluop codes.
- One sub-module: mips_mc_aludec (aluop, funct -> alucontrol), purely combinational.
- The FSM and output decode stay in mips_mc_controller.

Test Plan:
- Reset held 3 cycles, then released: state = 0 throughout reset, with pcen = irwrite = regwrite = memwrite = 0. First clock after release: pcen = 1, irwrite = 1.
- lw (op 100011): state sequence 0,1,2,3,4,0. MEMRD has iord = 1. MEMWB has memtoreg = 1 and regwrite = 1. alucontrol = 010 throughout.
- sw (op 101011): state sequence 0,1,2,5,0. memwrite = 1 for exactly one cycle, with iord = 1. regwrite is never asserted.
- R-type with funct 101010, then 100010, then 110000: alucontrol in RTYPEEX is 111, 110, then 010. RTYPEWB has regdst = 1 and regwrite = 1.
- beq with zero = 1: pcen = 1 and pcsrc = 01 in BEQEX. Same instruction with zero = 0: pcen = 0. Both return to FETCH after 3 clocks. j: JEX gives pcsrc = 10, pcen = 1.
- Unknown op 111111: with TRAP_UNKNOWN = 0, state goes 0,1,0. With TRAP_UNKNOWN = 1, state goes to 12 and stays there for 10+ cycles with halted = 1 and all enables 0; async reset returns state to 0. Separately, reset pulsed during MEMWR: memwrite drops with no clock edge.
